trace_capture: RTL
==================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 26, giving the captured sample width.
REQ-002 SHALL have parameter TRIG_W, default 17, giving the trigger input width.
REQ-003 SHALL have parameter DEPTH, default 1024, giving the sample buffer depth; power of two, at least 16.
REQ-004 SHALL define AW as log2(DEPTH), a localparam.
REQ-005 SHALL have port clk_in, input, 1 bit: single sampling clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port data_i, input, DATA_W bits: sampled data.
REQ-008 SHALL have port trig_i, input, TRIG_W bits: trigger source.
REQ-009 SHALL have ports trig_value_i and trig_mask_i, input, TRIG_W bits each: match pattern; mask bit 1 means the bit is compared.
REQ-010 SHALL have port trig_mode_i, input, 1 bit: 0 = level match, 1 = edge, i.e. match now and no match on the previous sample.
REQ-011 SHALL have port pre_trig_i, input, AW bits: number of samples to keep before the trigger.
REQ-012 SHALL have port arm_i, input, 1 bit: single-cycle pulse that starts a capture.
REQ-013 SHALL have port abort_i, input, 1 bit: pulse that returns the block to IDLE.
REQ-014 SHALL have ports rd_req_i, input, 1 bit, and rd_addr_i, input, AW bits: readback request; address 0 is the oldest sample.
REQ-015 SHALL have ports rd_data_o, output, DATA_W bits, and rd_valid_o, output, 1 bit: readback response.
REQ-016 SHALL have ports armed_o, triggered_o and done_o, output, 1 bit each: status flags.
REQ-017 SHALL have port trig_pos_o, output, AW bits: buffer index of the trigger sample, relative to the oldest sample.

Function
REQ-018 SHALL implement the FSM states IDLE, PRE, WAIT, POST and DONE.
REQ-019 SHALL, on arm_i in any state, latch pre_trig_i, clear the write pointer and sample counter, and go to PRE.
REQ-020 SHALL, while in PRE, WAIT or POST, write data_i at the write pointer every cycle and increment the pointer modulo DEPTH, wrapping silently.
REQ-021 SHALL, in PRE, ignore the trigger, and go to WAIT after pre_trig samples have been written; pre_trig = 0 goes to WAIT after the first write.
REQ-022 SHALL, in WAIT, on a trigger match record trig_ptr as the write pointer of the matching sample and go to POST.
REQ-023 SHALL, in POST, go to DONE after DEPTH-1-pre_trig further samples, so that exactly DEPTH samples are held around the trigger.
REQ-024 SHALL treat a trigger match as (trig_i XOR trig_value_i) AND trig_mask_i equal to 0; an all-zero mask matches on the first WAIT cycle.
REQ-025 SHALL, in edge mode, clear the previous-match register on arm, so that a match already present on the first WAIT cycle qualifies.
REQ-026 SHALL stop writing in DONE, hold the buffer until the next arm, and set trig_pos_o to pre_trig.
REQ-027 SHALL, in DONE, map rd_addr_i to physical address (trig_ptr - pre_trig + rd_addr_i) mod DEPTH.
REQ-028 SHALL return rd_data_o with rd_valid_o high exactly 1 cycle after rd_req_i.
REQ-029 SHALL, outside DONE, ignore rd_req_i and keep rd_valid_o at 0.
REQ-030 SHALL drive armed_o high in PRE and WAIT, triggered_o high in POST and DONE, and done_o high in DONE only.
REQ-031 SHALL, on abort_i, go to IDLE with all flags cleared; when abort_i and arm_i are asserted together, arm wins.

Reset
REQ-032 SHALL, on rst_in, asynchronously force state IDLE and clear the write pointer, trig_ptr, counters, all flags, rd_valid_o, rd_data_o and trig_pos_o.
REQ-033 SHALL NOT reset buffer contents.
REQ-034 SHALL, on reset mid-capture, discard the capture; a new arm_i is required.

Configuration
REQ-035 SHALL, when TRACE_TRIG_COUNT_EN is defined, add input trig_count_i (8 bits); the trigger fires on the Nth qualifying match in WAIT, where 0 and 1 both mean first; the match count is cleared on arm.
REQ-036 SHALL, when TRACE_TRIG_COUNT_EN is undefined, have no trig_count_i port and fire on the first match.

Structure
REQ-037 SHALL take the FSM state enum and the trig_mode constants (TRIG_LEVEL, TRIG_EDGE) from shared package trace_pkg.
REQ-038 SHALL hold the buffer in sub-module trace_ram: simple dual-port, one write port and one registered read port, inferable as block RAM.

Verification
REQ-039 SHALL verify basic capture: DEPTH=16, pre_trig=4, data_i = cycle count, level trigger on trig_i=0x00A5 appearing at sample 20 -> done_o high; addr 0..15 reads samples 16..31; trig_pos_o=4.
REQ-040 SHALL verify edge mode: trig_i held at a matching value from arm onward -> trigger on the first WAIT cycle only; a later repeated match causes no re-trigger.
REQ-041 SHALL verify wrap-around: DEPTH=16, pre_trig=15, trigger at sample 40 -> reads return 25..40; trig_pos_o=15.
REQ-042 SHALL verify abort and re-arm: abort_i asserted in POST -> flags 0; then arm_i -> clean capture; arm_i in DONE restarts and clears done_o.
REQ-043 SHALL verify readback gating: rd_req_i asserted in WAIT -> rd_valid_o stays 0; in DONE -> rd_valid_o 1 cycle later.
REQ-044 SHALL verify count trigger and reset: with TRACE_TRIG_COUNT_EN and trig_count_i=3, the trigger fires on the 3rd match; rst_in asserted in POST -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the trace capture block: capture FSM states and trigger-mode encodings.
package trace_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StPost,
    StDone
  } trace_state_e;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// Sample buffer: simple dual-port RAM, one write port and one registered read port.
module trace_ram #(
  parameter int unsigned Width = 26,
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Logic-analyser style trace capture with pre/post trigger window and readback.
// Optional build macro TRACE_TRIG_COUNT_EN: fire on the Nth qualifying trigger match.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 26,
  parameter int unsigned TRIG_W = 17,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic              trig_mode_i,
`ifdef TRACE_TRIG_COUNT_EN
  input  logic [7:0]        trig_count_i,
`endif
  input  logic [AW-1:0]     pre_trig_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              rd_req_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_pos_o
);

  trace_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pre_q, pre_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic          prev_match_q, prev_match_d;
  logic          rd_valid_q;

  logic          we;
  logic          match, qualify, fire;
  logic [AW-1:0] cnt_inc, post_len, rd_phys;
  logic [DATA_W-1:0] ram_rdata;

  assign match    = ((trig_i ^ trig_value_i) & trig_mask_i) == '0;
  assign qualify  = match && ((trig_mode_i == TRIG_LEVEL) || !prev_match_q);
  assign cnt_inc  = cnt_q + 1'b1;
  assign post_len = AW'(DEPTH - 1) - pre_q;

`ifdef TRACE_TRIG_COUNT_EN
  logic [7:0] match_cnt_q;
  logic       count_reached;

  // A count of 0 or 1 both fire on the first match.
  assign count_reached = ({1'b0, match_cnt_q} + 9'd1) >= {1'b0, trig_count_i};
  assign fire          = qualify && count_reached;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      match_cnt_q <= '0;
    end else if (arm_i) begin
      match_cnt_q <= '0;
    end else if (!abort_i && state_q == StWait && qualify && !count_reached) begin
      match_cnt_q <= match_cnt_q + 8'd1;
    end
  end
`else
  assign fire = qualify;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    trig_ptr_d   = trig_ptr_q;
    prev_match_d = prev_match_q;
    we           = 1'b0;
    if (arm_i) begin
      state_d      = StPre;
      pre_d        = pre_trig_i;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_match_d = 1'b0;
    end else if (abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StPre: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (pre_q == '0 || cnt_inc == pre_q) begin
            state_d = StWait;
          end
        end
        StWait: begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          prev_match_d = match;
          if (fire) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d      = '0;
            // With a full pre-trigger window the trigger sample is the last one kept.
            state_d    = (post_len == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == post_len) begin
            state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      trig_ptr_q   <= '0;
      prev_match_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      trig_ptr_q   <= trig_ptr_d;
      prev_match_q <= prev_match_d;
      rd_valid_q   <= rd_req_i && (state_q == StDone);
    end
  end

  assign rd_phys = trig_ptr_q - pre_q + rd_addr_i;

  trace_ram #(
    .Width(DATA_W),
    .Depth(DEPTH)
  ) u_ram (
    .clk_i  (clk_in),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_i),
    .re_i   (rd_req_i && (state_q == StDone)),
    .raddr_i(rd_phys),
    .rdata_o(ram_rdata)
  );

  // RAM output register has no reset; gate it so rd_data_o is zero after reset.
  assign rd_data_o   = rd_valid_q ? ram_rdata : '0;
  assign rd_valid_o  = rd_valid_q;
  assign armed_o     = (state_q == StPre) || (state_q == StWait);
  assign triggered_o = (state_q == StPost) || (state_q == StDone);
  assign done_o      = (state_q == StDone);
  assign trig_pos_o  = (state_q == StDone) ? pre_q : '0;

endmodule
